// File: rtl/spi_ram_arbiter.sv
// Two-requester round-robin arbiter serialising transactions onto a 10-bit SPI RAM command port.
// Latency: write done 3 cycles after req sample, read done 4+ (WAIT bounded by TIMEOUT); req ignored while busy.
module spi_ram_arbiter #(
    parameter int ADD_SIZE = 8,
    parameter int TIMEOUT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          op,
    input  logic [ADD_SIZE-1:0] addr0,
    input  logic [ADD_SIZE-1:0] addr1,
    input  logic [7:0]          wdata0,
    input  logic [7:0]          wdata1,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [7:0]          rdata,
    output logic                err,
    output logic                busy,
    output logic [9:0]          ram_din,
    output logic                ram_rx_valid,
    input  logic [7:0]          ram_dout,
    input  logic                ram_tx_valid
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT, RESP} state_t;

    state_t              state, next_state;
    logic                owner;
    logic                last_gnt;
    logic                win;
    logic                op_q;
    logic [ADD_SIZE-1:0] addr_q;
    logic [7:0]          wdata_q;
    logic [3:0]          cnt;
    logic                wait_end;

    // On a tie the requester not granted last wins; reset leaves last_gnt=1 so requester 0 is favoured.
    always_comb begin
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_gnt;
            default: win = 1'b0;
        endcase
    end

    assign wait_end = (cnt == 4'(TIMEOUT - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        gnt          = 2'b00;
        done         = 2'b00;
        ram_rx_valid = 1'b0;
        ram_din      = 10'h000;
        case (state)
            IDLE: if (|req) next_state = ADDR;
            ADDR: begin
                gnt[owner]   = 1'b1;
                ram_rx_valid = 1'b1;
                ram_din      = {op_q, 1'b0, addr_q};
                next_state   = DATA;
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = op_q ? 10'h300 : {1'b0, 1'b1, wdata_q};
                next_state   = op_q ? WAIT : RESP;
            end
            WAIT: if (ram_tx_valid || wait_end) next_state = RESP;
            RESP: begin
                done[owner] = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
            cnt      <= 4'd0;
            rdata    <= 8'h00;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req) begin
                    owner    <= win;
                    last_gnt <= win;
                    op_q     <= op[win];
                    addr_q   <= win ? addr1 : addr0;
                    wdata_q  <= win ? wdata1 : wdata0;
                    cnt      <= 4'd0;
                    rdata    <= 8'h00;
                    err      <= 1'b0;
                end
                WAIT: begin
                    if (ram_tx_valid) begin
                        rdata <= ram_dout;
                        err   <= 1'b0;
                        cnt   <= 4'd0;
                    end else if (wait_end) begin
                        rdata <= 8'h00;
                        err   <= 1'b1;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter ADD_SIZE, default 8: RAM address width; fixed at 8 because the command word carries addr in din[7:0].
REQ-002 SHALL have parameter TIMEOUT, default 4: maximum WAIT cycles for ram_tx_valid, range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, 2: per-requester transaction request; held by the requester until its gnt bit is seen.
REQ-006 SHALL have port op, input, 2: per-requester op; 0 = write, 1 = read.
REQ-007 SHALL have ports addr0/addr1, input, 8 each: per-requester RAM address.
REQ-008 SHALL have ports wdata0/wdata1, input, 8 each: per-requester write data.
REQ-009 SHALL have port gnt, output, 2: one-cycle acceptance pulse, one-hot or zero.
REQ-010 SHALL have port done, output, 2: one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port rdata, output, 8: read data; valid when done is high.
REQ-012 SHALL have port err, output, 1: read timeout flag; valid when done is high.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port ram_din, output, 10: command word to the RAM din.
REQ-015 SHALL have port ram_rx_valid, output, 1: command strobe to the RAM.
REQ-016 SHALL have ports ram_dout, input, 8, and ram_tx_valid, input, 1: RAM read return.

Function
REQ-017 SHALL implement the FSM IDLE -> ADDR -> DATA -> (write: RESP | read: WAIT -> RESP) -> IDLE, one cycle per state except WAIT.
REQ-018 In IDLE with any req bit high, SHALL select a winner, latch its op, addr and wdata plus the owner index, and enter ADDR; gnt[winner] SHALL be high during the ADDR cycle.
REQ-019 Arbitration SHALL be round-robin: a lone requester wins; on a tie, the requester not granted last wins; the pointer SHALL update on every grant.
REQ-020 ADDR SHALL drive ram_rx_valid=1 and ram_din={op,1'b0,addr}.
REQ-021 DATA SHALL drive ram_rx_valid=1 and ram_din={op,1'b1,wdata} for a write, or {2'b11,8'h00} for a read.
REQ-022 ram_rx_valid SHALL be 0 and ram_din SHALL be 0 in IDLE, WAIT and RESP.
REQ-023 WAIT SHALL count cycles from 0. On ram_tx_valid=1, it SHALL capture ram_dout into rdata, clear err and enter RESP. If the count reaches TIMEOUT with no tx_valid, it SHALL set rdata=0, err=1 and enter RESP.
REQ-024 RESP SHALL pulse done[owner] for one cycle with rdata and err valid, then return to IDLE. For writes, rdata=0 and err=0.
REQ-025 Latency from req sampled in IDLE SHALL be: write done 3 cycles later; read done 4 cycles later when the RAM answers on the first WAIT cycle.
REQ-026 req SHALL be ignored outside IDLE; a pending req SHALL be arbitrated on the first IDLE cycle, giving back-to-back transactions with one IDLE cycle between them.
REQ-027 ram_tx_valid outside WAIT SHALL be ignored.
REQ-028 Changes on op, addr or wdata after the grant SHALL not affect the transaction in flight.

Reset
REQ-029 With rst high at a clock edge, SHALL enter IDLE; gnt, done, rdata, err, busy, ram_din, ram_rx_valid and the WAIT counter SHALL be 0; the round-robin pointer SHALL favour requester 0.
REQ-030 rst mid-transaction SHALL abort it without a done pulse; ram_rx_valid SHALL be low on the cycle after the reset edge.

Verification
REQ-031 Req0 writes addr 0x3C with data 0xA5 -> ram_din 0x03C then 0x1A5 on consecutive cycles, done[0] 3 cycles after the req sample, err=0.
REQ-032 Req1 reads 0x3C after the write, with a RAM model that answers on the first WAIT cycle -> ram_din 0x23C then 0x300, done[1] 4 cycles after the req sample, rdata=0xA5.
REQ-033 req=2'b11 held continuously for 4 transactions -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-034 Read with ram_tx_valid tied low and TIMEOUT=4 -> done pulse with err=1 and rdata=0 after 4 WAIT cycles, then IDLE.
REQ-035 rst asserted during DATA -> no done pulse, ram_rx_valid=0 the next cycle, and the next req0 is granted normally.
